// File: rtl/amm_mem_responder.sv
// Avalon-MM burst memory responder: stores write bursts in an internal word
// array and returns read bursts after a fixed latency, with optional
// pseudo-random waitrequest stalls and a sticky protocol-violation flag.
module amm_mem_responder #(
    parameter int unsigned AMM_ADDR_W  = 31,
    parameter int unsigned AMM_DATA_W  = 128,
    parameter int unsigned AMM_BURST_W = 11,
    parameter int unsigned DATA_B_W    = 16,
    parameter int unsigned MEM_DEPTH_W = 10,
    parameter int unsigned RD_LATENCY  = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AMM_ADDR_W-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [AMM_DATA_W-1:0]  writedata_i,
    input  logic [AMM_BURST_W-1:0] burstcount_i,
    input  logic [DATA_B_W-1:0]    byteenable_i,
    output logic                   waitrequest_o,
    output logic                   readdatavalid_o,
    output logic [AMM_DATA_W-1:0]  readdata_o,
    input  logic                   rand_wait_en_i,
    output logic                   proto_err_o
);

    localparam int unsigned MEM_WORDS = 1 << MEM_DEPTH_W;
    localparam int unsigned WAIT_W    = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_DATA} state_t;

    logic [AMM_DATA_W-1:0]  mem [MEM_WORDS];

    state_t                 state_q, state_d;
    logic [15:0]            lfsr_q;
    logic [MEM_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AMM_BURST_W-1:0] wr_left_q, wr_left_d, rd_left_q, rd_left_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;

    logic                   stall_c, wait_req_c, mem_we_c, issue_c, err_set_c, rvalid_c;
    logic [MEM_DEPTH_W-1:0] mem_widx_c, issue_idx_c, base_c;
    logic [AMM_BURST_W-1:0] count_c;
    logic                   bc_zero_c;
    logic                   unused_addr_c;

    assign base_c        = address_i[MEM_DEPTH_W-1:0];
    assign bc_zero_c     = (burstcount_i == '0);
    assign count_c       = bc_zero_c ? AMM_BURST_W'(1) : burstcount_i;
    assign stall_c       = rand_wait_en_i & lfsr_q[0];
    assign waitrequest_o = rst_i | wait_req_c;
    assign unused_addr_c = ^address_i[AMM_ADDR_W-1:MEM_DEPTH_W];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state, burst bookkeeping and per-cycle memory/readback controls
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_left_d   = wr_left_q;
        rd_ptr_d    = rd_ptr_q;
        rd_left_d   = rd_left_q;
        wait_d      = wait_q;
        wait_req_c  = 1'b1;
        mem_we_c    = 1'b0;
        mem_widx_c  = wr_ptr_q;
        issue_c     = 1'b0;
        issue_idx_c = rd_ptr_q;
        err_set_c   = 1'b0;
        rvalid_c    = 1'b0;
        case (state_q)
            IDLE: begin
                wait_req_c = stall_c;
                if (write_i && !stall_c) begin
                    mem_we_c   = 1'b1;
                    mem_widx_c = base_c;
                    err_set_c  = bc_zero_c | read_i;
                    if (count_c != AMM_BURST_W'(1)) begin
                        state_d   = WR_BURST;
                        wr_left_d = count_c - AMM_BURST_W'(1);
                        wr_ptr_d  = base_c + MEM_DEPTH_W'(1);
                    end
                end else if (read_i && !stall_c) begin
                    err_set_c = bc_zero_c;
                    if (RD_LATENCY <= 1) begin
                        // Latency of one: the first beat is fetched on the accept edge
                        issue_c     = 1'b1;
                        issue_idx_c = base_c;
                        rvalid_c    = 1'b1;
                        rd_ptr_d    = base_c + MEM_DEPTH_W'(1);
                        rd_left_d   = count_c - AMM_BURST_W'(1);
                        state_d     = RD_DATA;
                    end else begin
                        rd_ptr_d  = base_c;
                        rd_left_d = count_c;
                        wait_d    = WAIT_W'(RD_LATENCY - 2);
                        state_d   = RD_WAIT;
                    end
                end
            end
            WR_BURST: begin
                wait_req_c = stall_c;
                err_set_c  = read_i;
                if (write_i && !stall_c) begin
                    mem_we_c   = 1'b1;
                    mem_widx_c = wr_ptr_q;
                    wr_ptr_d   = wr_ptr_q + MEM_DEPTH_W'(1);
                    wr_left_d  = wr_left_q - AMM_BURST_W'(1);
                    if (wr_left_q == AMM_BURST_W'(1)) state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (wait_q == '0) begin
                    issue_c   = 1'b1;
                    rvalid_c  = 1'b1;
                    rd_ptr_d  = rd_ptr_q + MEM_DEPTH_W'(1);
                    rd_left_d = rd_left_q - AMM_BURST_W'(1);
                    state_d   = RD_DATA;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            RD_DATA: begin
                // rd_left counts beats not yet fetched; zero means the visible beat is the last
                if (rd_left_q != '0) begin
                    issue_c   = 1'b1;
                    rvalid_c  = 1'b1;
                    rd_ptr_d  = rd_ptr_q + MEM_DEPTH_W'(1);
                    rd_left_d = rd_left_q - AMM_BURST_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers, LFSR and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q          <= LFSR_SEED;
            wr_ptr_q        <= '0;
            wr_left_q       <= '0;
            rd_ptr_q        <= '0;
            rd_left_q       <= '0;
            wait_q          <= '0;
            readdatavalid_o <= 1'b0;
            readdata_o      <= '0;
            proto_err_o     <= 1'b0;
        end else begin
            lfsr_q          <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            wr_ptr_q        <= wr_ptr_d;
            wr_left_q       <= wr_left_d;
            rd_ptr_q        <= rd_ptr_d;
            rd_left_q       <= rd_left_d;
            wait_q          <= wait_d;
            readdatavalid_o <= rvalid_c;
            if (issue_c)   readdata_o  <= mem[issue_idx_c];
            if (err_set_c) proto_err_o <= 1'b1;
        end
    end

    // Storage write port with per-byte enables; contents survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we_c && !rst_i) begin
            for (int unsigned b = 0; b < DATA_B_W; b++) begin
                if (byteenable_i[b]) mem[mem_widx_c][b*8 +: 8] <= writedata_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_amm_mem_responder.sv
// Bench for amm_mem_responder: directed cases plus randomized bursts with
// stalls, checked against a word-array reference model.
module tb_amm_mem_responder;

    localparam int LAT   = 4;
    localparam int WORDS = 1024;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [30:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [127:0] writedata_i;
    logic [10:0]  burstcount_i;
    logic [15:0]  byteenable_i;
    logic         waitrequest_o;
    logic         readdatavalid_o;
    logic [127:0] readdata_o;
    logic         rand_wait_en_i;
    logic         proto_err_o;

    amm_mem_responder dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .address_i       (address_i),
        .read_i          (read_i),
        .write_i         (write_i),
        .writedata_i     (writedata_i),
        .burstcount_i    (burstcount_i),
        .byteenable_i    (byteenable_i),
        .waitrequest_o   (waitrequest_o),
        .readdatavalid_o (readdatavalid_o),
        .readdata_o      (readdata_o),
        .rand_wait_en_i  (rand_wait_en_i),
        .proto_err_o     (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference model: plain word array plus "fully known" flags
    logic [127:0] mem_m  [WORDS];
    bit           mvalid [WORDS];

    logic [127:0] wdat [16];
    logic [15:0]  wbe  [16];

    int n_checks = 0;
    int n_pass   = 0;
    int last_acc = 0;
    int stalls   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Wait until the currently driven request is accepted; returns at posedge+1
    task automatic accept_wait(inout int waits);
        int t = 0;
        @(negedge clk_i);
        while (waitrequest_o && t < 200) begin
            t++;
            waits++;
            @(negedge clk_i);
        end
        if (t >= 200) check("accept_timeout", 128'(t), 128'(0));
        last_acc = cyc;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr_burst(input logic [30:0] addr, input int n, input logic [10:0] bc,
                            input bit rd_too, output int waits);
        int idx;
        waits = 0;
        for (int k = 0; k < n; k++) begin
            write_i      = 1'b1;
            read_i       = rd_too && (k == 0);
            writedata_i  = wdat[k];
            byteenable_i = wbe[k];
            address_i    = (k == 0) ? addr : 31'($urandom);
            burstcount_i = (k == 0) ? bc : 11'($urandom);
            accept_wait(waits);
            idx = (int'(addr) + k) % WORDS;
            for (int b = 0; b < 16; b++)
                if (wbe[k][b]) mem_m[idx][b*8 +: 8] = wdat[k][b*8 +: 8];
            if (wbe[k] == 16'hFFFF) mvalid[idx] = 1'b1;
        end
        write_i = 1'b0;
        read_i  = 1'b0;
    endtask

    task automatic rd_burst(input logic [30:0] addr, input logic [10:0] bc, input int nexp);
        int w = 0, acc, got = 0, t = 0, first = -1, gaps = 0, wr_low = 0, idx;
        logic [127:0] last_d = '0;
        read_i       = 1'b1;
        address_i    = addr;
        burstcount_i = bc;
        accept_wait(w);
        stalls += w;
        acc    = last_acc;
        read_i = 1'b0;
        while (got < nexp && t < 100) begin
            @(negedge clk_i);
            t++;
            if (!waitrequest_o) wr_low++;
            if (readdatavalid_o) begin
                if (first < 0) first = cyc;
                else if (cyc != first + got) gaps++;
                idx = (int'(addr) + got) % WORDS;
                if (mvalid[idx]) check("rd_data", readdata_o, mem_m[idx]);
                last_d = readdata_o;
                got++;
            end
        end
        check("rd_beats", 128'(got), 128'(nexp));
        check("rd_latency", 128'(first - acc), 128'(LAT));
        check("rd_gaps", 128'(gaps), 128'(0));
        check("rd_waitreq_high", 128'(wr_low), 128'(0));
        @(negedge clk_i);
        check("rd_valid_drop", 128'(readdatavalid_o), 128'(0));
        check("rd_data_hold", readdata_o, last_d);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        repeat (n) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int w, n, vcount;
        logic [30:0] a;
        rst_i = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0;
        writedata_i = '0; burstcount_i = 11'd1; byteenable_i = '1; rand_wait_en_i = 1'b0;
        for (int i = 0; i < WORDS; i++) begin mem_m[i] = '0; mvalid[i] = 1'b0; end

        // Reset values
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_waitreq", 128'(waitrequest_o), 128'(1));
        check("rst_rvalid", 128'(readdatavalid_o), 128'(0));
        check("rst_rdata", readdata_o, 128'(0));
        check("rst_perr", 128'(proto_err_o), 128'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Basic 4-beat write then read at 0x10
        for (int k = 0; k < 4; k++) begin wdat[k] = rnd128(); wbe[k] = 16'hFFFF; end
        wr_burst(31'h10, 4, 11'd4, 1'b0, w);
        check("wr_no_wait", 128'(w), 128'(0));
        rd_burst(31'h10, 11'd4, 4);
        check("basic_last_word", readdata_o, wdat[3]);

        // Byteenable merge on word 5
        wdat[0] = '1; wbe[0] = 16'hFFFF;
        wr_burst(31'h5, 1, 11'd1, 1'b0, w);
        wdat[0] = '0; wbe[0] = 16'h00F0;
        wr_burst(31'h5, 1, 11'd1, 1'b0, w);
        rd_burst(31'h5, 11'd1, 1);
        check("be_merge", readdata_o, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);

        // Wrap at top of storage
        for (int k = 0; k < 3; k++) begin wdat[k] = rnd128(); wbe[k] = 16'hFFFF; end
        wr_burst(31'h3FF, 3, 11'd3, 1'b0, w);
        rd_burst(31'h3FF, 11'd3, 3);
        rd_burst(31'h0, 11'd1, 1);
        check("wrap_word0", readdata_o, wdat[1]);
        rd_burst(31'h7FFF_FC01, 11'd1, 1);
        check("wrap_word1_hiaddr", readdata_o, wdat[2]);

        // Randomized bursts with stalls
        rand_wait_en_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            n = $urandom_range(1, 16);
            a = {21'($urandom), 10'((32'h3F0 + $urandom_range(0, 63)) & 32'h3FF)};
            if (i < 8 || $urandom_range(0, 1) == 1) begin
                for (int k = 0; k < n; k++) begin
                    wdat[k] = rnd128();
                    wbe[k]  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
                end
                wr_burst(a, n, 11'(n), 1'b0, w);
                stalls += w;
            end else begin
                rd_burst(a, 11'(n), n);
            end
        end
        check("stall_seen", 128'(stalls > 0), 128'(1));
        check("rand_perr_clear", 128'(proto_err_o), 128'(0));
        rand_wait_en_i = 1'b0;

        // read_i and write_i together with burstcount 0: write wins, read dropped
        wdat[0] = rnd128(); wbe[0] = 16'hFFFF;
        wr_burst(31'h7, 1, 11'd0, 1'b1, w);
        vcount = 0;
        repeat (10) begin @(negedge clk_i); if (readdatavalid_o) vcount++; end
        check("viol_read_dropped", 128'(vcount), 128'(0));
        check("viol_perr", 128'(proto_err_o), 128'(1));
        @(posedge clk_i); #1;
        rd_burst(31'h7, 11'd1, 1);
        check("viol_write_done", readdata_o, wdat[0]);
        check("viol_perr_sticky", 128'(proto_err_o), 128'(1));
        do_reset(2);
        @(negedge clk_i);
        check("perr_cleared", 128'(proto_err_o), 128'(0));
        @(posedge clk_i); #1;

        // burstcount 0 alone: one beat, next write is a fresh command
        wdat[0] = rnd128(); wbe[0] = 16'hFFFF;
        wr_burst(31'h9, 1, 11'd0, 1'b0, w);
        @(negedge clk_i);
        check("bc0_perr", 128'(proto_err_o), 128'(1));
        @(posedge clk_i); #1;
        wdat[0] = rnd128();
        wr_burst(31'h64, 1, 11'd1, 1'b0, w);
        rd_burst(31'h64, 11'd1, 1);
        check("bc0_next_cmd", readdata_o, wdat[0]);
        rd_burst(31'h9, 11'd0, 1);
        do_reset(2);

        // Reset during an 8-beat read
        for (int k = 0; k < 8; k++) begin wdat[k] = rnd128(); wbe[k] = 16'hFFFF; end
        wr_burst(31'h40, 8, 11'd8, 1'b0, w);
        read_i = 1'b1; address_i = 31'h40; burstcount_i = 11'd8;
        w = 0;
        accept_wait(w);
        read_i = 1'b0;
        vcount = 0;
        n = 0;
        while (vcount < 2 && n < 50) begin
            @(negedge clk_i);
            n++;
            if (readdatavalid_o) vcount++;
        end
        check("rst_mid_beats_seen", 128'(vcount), 128'(2));
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_rvalid", 128'(readdatavalid_o), 128'(0));
        check("rst_mid_waitreq", 128'(waitrequest_o), 128'(1));
        @(negedge clk_i);
        check("rst_mid_waitreq2", 128'(waitrequest_o), 128'(1));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        vcount = 0;
        repeat (12) begin @(negedge clk_i); if (readdatavalid_o) vcount++; end
        check("rst_mid_no_more_beats", 128'(vcount), 128'(0));
        @(posedge clk_i); #1;
        wdat[0] = rnd128(); wbe[0] = 16'hFFFF;
        wr_burst(31'h80, 1, 11'd1, 1'b0, w);
        check("post_rst_wr_no_wait", 128'(w), 128'(0));
        rd_burst(31'h80, 11'd1, 1);
        check("post_rst_write", readdata_o, wdat[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
